posit_decode: RTL
=================

// Module: posit_decode
// PURPOSE
//   Sequential posit<32,3> field decoder, the inverse of the rounding/packing path. Accepts a
//   32-bit posit word on a start pulse and splits it into sign, regime value k, 3-bit
//   exponent and left-aligned fraction, plus the fraction bit count nbt. The fields use the
//   same formats the arithmetic datapath consumes, so decoded operands feed the multiply/add
//   stages directly. The regime run is scanned one bit per clock, so latency depends on the data.
// PARAMETERS
//   POSIT_W  32  posit word width (only 32 supported/verified)
//   ES       3   exponent field width (only 3 supported/verified)
// PORTS
//   clk           in   1   rising-edge clock
//   rst           in   1   asynchronous, active-high reset
//   start         in   1   decode request; sampled only in IDLE
//   posit_in      in   32  posit word; captured on the edge that accepts start
//   sign_out      out  1   posit sign bit
//   k_out         out  6   regime value, two's complement (-30..+30)
//   exp_out       out  3   exponent field, zero-padded if truncated
//   mantissa_out  out  32  fraction bits, MSB-aligned at bit 31, zero below; no hidden bit
//   nbt_out       out  6   number of valid fraction bits (0..26)
//   is_zero       out  1   input was 32'h0000_0000
//   is_nar        out  1   input was 32'h8000_0000 (NaR)
//   busy          out  1   high in every state except IDLE
//   done          out  1   one-cycle pulse; all outputs valid from this cycle on
// BEHAVIOUR
// - Reset: FSM to IDLE. All outputs and internal registers go to 0. Reset mid-decode aborts it with no done.
// - FSM states: IDLE -> LOAD -> SCAN (loops) -> EXTRACT -> DONE -> IDLE. Special values take LOAD -> DONE.
// - IDLE: on start=1, capture posit_in and go to LOAD. start in any other state is ignored.
// - LOAD: sign = p[31]; mag = sign ? -p : p (32-bit two's complement).
//   p==0 sets is_zero=1. p==0x8000_0000 sets is_nar=1.
//   In both cases sign/k/exp/mantissa/nbt = 0 (sign=1 for NaR) and the FSM goes straight to DONE.
//   Otherwise r0 = mag[30], run = 1, idx = 29, go to SCAN.
// - SCAN: one bit per cycle.
//   If mag[idx]==r0: run++, idx--. If that bit was idx 0, set t=0 and go to EXTRACT.
//   If mag[idx]!=r0: the terminator is at t=idx; go to EXTRACT.
// - EXTRACT:
//   k = r0 ? run-1 : -run.
//   exp = mag bits t-1..t-3, with positions below bit 0 read as 0 (run=31 case: exp=0).
//   nbt = (t>3) ? t-3 : 0.
//   mantissa = mag bits t-4..0 placed at bits 31..(35-t), zero elsewhere; 0 if nbt=0.
//   Output registers load on this edge; go to DONE.
// - DONE: done=1 for exactly one cycle, then IDLE. Outputs hold until the next accepted start.
//   On that start, is_zero/is_nar clear; the field outputs update only at the next EXTRACT or LOAD-special edge.
// - Latency: count from edge 0, the edge that accepts start. done is high in the cycle after
//   edge m+2 for a terminated run of length m (1..30), edge 32 for run=31, edge 1 for zero/NaR.
// - Width rules: run is 5 bits (max 31); k fits 6-bit signed; nbt is never negative.
//   Special-value detection runs on p, not on mag.
// - Round trip: feeding sign/k/exp/mantissa back through the packing path must reproduce p exactly.
// TESTING
// 1. posit_in=0x4000_0000 -> sign0 k=0 exp=0 mant=0 nbt=26; done high after edge 3.
// 2. posit_in=0x4A80_0000 -> sign0 k=0 exp=3'd2 mant=0xA000_0000 nbt=26.
//    Then 0xB580_0000 -> same fields with sign1.
// 3. 0x7FFF_FFFF -> k=6'h1E exp=0 mant=0 nbt=0, done after edge 32.
//    0x0000_0001 -> k=6'h22 (-30) exp=0 nbt=0, done after edge 32.
// 4. 0x0000_0000 -> is_zero=1, all fields 0.
//    0x8000_0000 -> is_nar=1, sign=1.
//    Both: done after edge 1.
// 5. Pulse start with 0x1234_5678 during SCAN of 0x7FFF_FFFF -> ignored; 0x7FFF_FFFF result is unchanged.
// 6. Assert rst mid-SCAN -> outputs 0, busy=0, no done.
//    A fresh start after reset decodes correctly.
//    Random sweep of 10k words, round-tripped through the packing path -> bit-exact.

Source files
------------

// File: rtl/posit_decode.sv
// posit_decode: sequential posit<32,3> field decoder.
// Captures a posit word on start and splits it into sign, regime value k,
// exponent, left-aligned fraction and fraction bit count. The regime run is
// scanned one bit per clock, so latency depends on the data.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          decode request, sampled only in IDLE
//   posit_in       posit word, captured on the edge that accepts start
//   sign_out       posit sign bit
//   k_out          regime value, two's complement (-30..+30)
//   exp_out        exponent field, zero-padded when truncated
//   mantissa_out   fraction bits MSB-aligned at bit 31, no hidden bit
//   nbt_out        number of valid fraction bits (0..26)
//   is_zero/is_nar special-value flags
//   busy           high in every state except IDLE
//   done           one-cycle pulse, outputs valid from this cycle on
module posit_decode #(
  parameter int unsigned POSIT_W = 32,
  parameter int unsigned ES      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [POSIT_W-1:0] posit_in,
  output logic               sign_out,
  output logic [5:0]         k_out,
  output logic [ES-1:0]      exp_out,
  output logic [POSIT_W-1:0] mantissa_out,
  output logic [5:0]         nbt_out,
  output logic               is_zero,
  output logic               is_nar,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_EXTRACT,
    S_DONE
  } state_t;

  state_t             state_q;
  // Holds the raw posit in LOAD, then the magnitude from SCAN onwards.
  logic [POSIT_W-1:0] word_q;
  logic               sign_q;
  logic               r0_q;
  logic [4:0]         run_q;
  logic [4:0]         idx_q;
  logic [4:0]         t_q;

  logic [POSIT_W-1:0] mag_d;
  logic [POSIT_W+2:0] ext_d;
  logic [ES-1:0]      exp_d;
  logic [5:0]         nbt_d;
  logic [5:0]         shift_d;
  logic [POSIT_W-1:0] mant_d;
  logic [5:0]         k_d;

  always_comb begin
    mag_d   = word_q[POSIT_W-1] ? (~word_q + 1'b1) : word_q;
    // Three zero bits appended below bit 0 so a truncated exponent reads as 0.
    ext_d   = {word_q, 3'b000};
    exp_d   = ext_d[t_q +: ES];
    nbt_d   = (t_q > 5'd3) ? ({1'b0, t_q} - 6'd3) : '0;
    // Fraction starts at bit t-4; shifting by 35-t lands it at bit 31 and
    // pushes regime/exponent bits out of the top.
    shift_d = 6'd35 - {1'b0, t_q};
    mant_d  = (nbt_d == '0) ? '0 : (word_q << shift_d);
    k_d     = r0_q ? ({1'b0, run_q} - 6'd1) : (6'd0 - {1'b0, run_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      sign_q       <= 1'b0;
      r0_q         <= 1'b0;
      run_q        <= '0;
      idx_q        <= '0;
      t_q          <= '0;
      sign_out     <= 1'b0;
      k_out        <= '0;
      exp_out      <= '0;
      mantissa_out <= '0;
      nbt_out      <= '0;
      is_zero      <= 1'b0;
      is_nar       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            word_q  <= posit_in;
            is_zero <= 1'b0;
            is_nar  <= 1'b0;
            busy    <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (word_q == '0 || word_q == {1'b1, {(POSIT_W-1){1'b0}}}) begin
            is_zero      <= (word_q == '0);
            is_nar       <= (word_q != '0);
            sign_out     <= word_q[POSIT_W-1];
            k_out        <= '0;
            exp_out      <= '0;
            mantissa_out <= '0;
            nbt_out      <= '0;
            done         <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            sign_q  <= word_q[POSIT_W-1];
            word_q  <= mag_d;
            r0_q    <= mag_d[POSIT_W-2];
            run_q   <= 5'd1;
            idx_q   <= 5'd29;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (word_q[idx_q] == r0_q) begin
            run_q <= run_q + 5'd1;
            if (idx_q == '0) begin
              t_q     <= '0;
              state_q <= S_EXTRACT;
            end else begin
              idx_q <= idx_q - 5'd1;
            end
          end else begin
            t_q     <= idx_q;
            state_q <= S_EXTRACT;
          end
        end
        S_EXTRACT: begin
          sign_out     <= sign_q;
          k_out        <= k_d;
          exp_out      <= exp_d;
          mantissa_out <= mant_d;
          nbt_out      <= nbt_d;
          done         <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
